// File: rtl/brownout_sup_pkg.sv
// Shared types and default sizing for the brownout supervisor slice.
package brownout_sup_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RUN   = 2'd1,
    ST_BROWN = 2'd2,
    ST_HOLD  = 2'd3
  } sup_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_W      = 4;
  localparam int DEF_HOLD_W      = 16;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/brownout_deglitch.sv
// Synchroniser plus run-length deglitch filter for one async level, with a rise strobe.
// The strobe is a one-cycle pulse coincident with the first cycle filt_o reads 1.
module brownout_deglitch #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              async_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              filt_o,
  output logic              rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt_q, filt_d;
  logic [FILT_W-1:0]      run_q, run_d;
  logic                   rise_q, rise_d;

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (synced != filt_q) begin
      // Flip on the (filt_len+1)-th consecutive mismatching sample.
      if (run_q == filt_len_i) begin
        filt_d = synced;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
    if (flush_i) begin
      filt_d = 1'b0;
      run_d  = '0;
    end
    rise_d = filt_d & ~filt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      run_q  <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      filt_q <= filt_d;
      run_q  <= run_d;
      rise_q <= rise_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/brownout_supervisor.sv
// Turns the brownout macro outputs into a system reset with hold-off, sticky status
// flags, a saturating event counter and a level interrupt.
module brownout_supervisor
  import brownout_sup_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W,
  parameter int HOLD_W      = DEF_HOLD_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              bo_in,
  input  logic              vunder_in,
  input  logic              timed_out_in,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              clr,
  output logic              sys_rst,
  output logic              bo_flag,
  output logic              vunder_flag,
  output logic              to_flag,
  output logic              irq,
  output logic [CNT_W-1:0]  evt_cnt,
  output logic [1:0]        state
);

  sup_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  evt_cnt_q, evt_cnt_d;
  logic              bo_flag_q, bo_flag_d;
  logic              vunder_flag_q, vunder_flag_d;
  logic              to_flag_q, to_flag_d;
  logic              irq_q;
  logic              sys_rst_q;
  logic              bo_evt;
  logic              flush;
  logic              bo_filt, bo_rise;
  logic              vu_filt, vu_rise;
  logic              to_filt, to_rise;
  logic              unused_ok;

  // Filters are flushed once, on the edge into OFF, so they re-qualify while disabled.
  assign flush = ~ena && (state_q != ST_OFF);

  brownout_deglitch #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_bo_dg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .async_i    (bo_in),
    .filt_len_i (filt_len),
    .filt_o     (bo_filt),
    .rise_o     (bo_rise)
  );

  brownout_deglitch #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_vu_dg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .async_i    (vunder_in),
    .filt_len_i (filt_len),
    .filt_o     (vu_filt),
    .rise_o     (vu_rise)
  );

  brownout_deglitch #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_to_dg (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .async_i    (timed_out_in),
    .filt_len_i ({FILT_W{1'b0}}),
    .filt_o     (to_filt),
    .rise_o     (to_rise)
  );

  assign unused_ok = ^{bo_rise, vu_filt, to_filt};

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    bo_evt     = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bo_filt) begin
          state_d = ST_BROWN;
          bo_evt  = 1'b1;
        end
      end
      ST_BROWN: begin
        if (!bo_filt) begin
          state_d    = ST_HOLD;
          hold_cnt_d = hold_len;
        end
      end
      ST_HOLD: begin
        if (bo_filt) begin
          state_d = ST_BROWN;
        end else if (hold_cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    if (!ena) begin
      state_d    = ST_OFF;
      hold_cnt_d = '0;
      bo_evt     = 1'b0;
    end
  end

  // Clear first, then set, so a coincident set survives a clr pulse.
  always_comb begin
    bo_flag_d     = clr ? 1'b0 : bo_flag_q;
    vunder_flag_d = clr ? 1'b0 : vunder_flag_q;
    to_flag_d     = clr ? 1'b0 : to_flag_q;
    evt_cnt_d     = clr ? '0 : evt_cnt_q;
    if (bo_evt) begin
      bo_flag_d = 1'b1;
      if (clr) begin
        evt_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (evt_cnt_q != '1) begin
        evt_cnt_d = evt_cnt_q + 1'b1;
      end
    end
    if (state_q != ST_OFF) begin
      if (vu_rise) vunder_flag_d = 1'b1;
      if (to_rise) to_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_OFF;
      hold_cnt_q    <= '0;
      evt_cnt_q     <= '0;
      bo_flag_q     <= 1'b0;
      vunder_flag_q <= 1'b0;
      to_flag_q     <= 1'b0;
      irq_q         <= 1'b0;
      sys_rst_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      evt_cnt_q     <= evt_cnt_d;
      bo_flag_q     <= bo_flag_d;
      vunder_flag_q <= vunder_flag_d;
      to_flag_q     <= to_flag_d;
      irq_q         <= bo_flag_q | vunder_flag_q | to_flag_q;
      sys_rst_q     <= (state_d == ST_BROWN) || (state_d == ST_HOLD);
    end
  end

  assign sys_rst     = sys_rst_q;
  assign bo_flag     = bo_flag_q;
  assign vunder_flag = vunder_flag_q;
  assign to_flag     = to_flag_q;
  assign irq         = irq_q;
  assign evt_cnt     = evt_cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_brownout_supervisor.sv
// Directed bench for brownout_supervisor: inputs driven and outputs sampled on the falling edge.
module tb_brownout_supervisor;

  logic        clk = 1'b0;
  logic        rst, ena, bo_in, vunder_in, timed_out_in, clr;
  logic [3:0]  filt_len;
  logic [15:0] hold_len;
  logic        sys_rst, bo_flag, vunder_flag, to_flag, irq;
  logic [7:0]  evt_cnt;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] S_OFF = 2'd0, S_RUN = 2'd1, S_BROWN = 2'd2, S_HOLD = 2'd3;

  always #5 clk = ~clk;

  brownout_supervisor dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .bo_in        (bo_in),
    .vunder_in    (vunder_in),
    .timed_out_in (timed_out_in),
    .filt_len     (filt_len),
    .hold_len     (hold_len),
    .clr          (clr),
    .sys_rst      (sys_rst),
    .bo_flag      (bo_flag),
    .vunder_flag  (vunder_flag),
    .to_flag      (to_flag),
    .irq          (irq),
    .evt_cnt      (evt_cnt),
    .state        (state)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, output bit ok);
    int n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    ok = (state === s);
  endtask

  task automatic bo_event(output bit ok);
    bit ok1, ok2;
    bo_in = 1'b1;
    wait_state(S_BROWN, 20, ok1);
    bo_in = 1'b0;
    wait_state(S_RUN, 20, ok2);
    ok = ok1 && ok2;
  endtask

  initial begin
    bit ok, all_ok;
    rst = 1'b1; ena = 1'b0; bo_in = 1'b0; vunder_in = 1'b0; timed_out_in = 1'b0;
    clr = 1'b0; filt_len = 4'd3; hold_len = 16'd10;
    tick(3);
    check("rst_state", state, S_OFF);
    check("rst_sys_rst", sys_rst, 0);
    check("rst_evt_cnt", evt_cnt, 0);
    check("rst_flags", {bo_flag, vunder_flag, to_flag}, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0; ena = 1'b1;
    check("pre_ena_state", state, S_OFF);
    tick(1);
    check("ena_state_run", state, S_RUN);

    // 3-cycle glitch must be rejected with filt_len=3
    bo_in = 1'b1; tick(3); bo_in = 1'b0; tick(10);
    check("glitch_sys_rst", sys_rst, 0);
    check("glitch_evt_cnt", evt_cnt, 0);
    check("glitch_state", state, S_RUN);

    // Held rise: sys_rst asserts exactly 7 edges later
    bo_in = 1'b1; tick(6);
    check("lat6_sys_rst", sys_rst, 0);
    tick(1);
    check("lat7_sys_rst", sys_rst, 1);
    check("lat7_state", state, S_BROWN);
    check("lat7_evt_cnt", evt_cnt, 1);
    check("lat7_bo_flag", bo_flag, 1);
    check("lat7_irq_lag", irq, 0);
    tick(1);
    check("irq_set", irq, 1);

    // Hold-off of hold_len+1 cycles
    bo_in = 1'b0;
    wait_state(S_HOLD, 20, ok);
    check("hold_entry", state, S_HOLD);
    check("hold_sys_rst", sys_rst, 1);
    tick(10);
    check("hold10_state", state, S_HOLD);
    check("hold10_sys_rst", sys_rst, 1);
    tick(1);
    check("hold11_state", state, S_RUN);
    check("hold11_sys_rst", sys_rst, 0);

    // Re-rise during HOLD returns to BROWN without counting
    bo_in = 1'b1;
    wait_state(S_BROWN, 20, ok);
    check("rerise_brown1", state, S_BROWN);
    check("rerise_evt1", evt_cnt, 2);
    bo_in = 1'b0;
    wait_state(S_HOLD, 20, ok);
    check("rerise_hold", state, S_HOLD);
    bo_in = 1'b1;
    tick(6);
    check("rerise_still_hold", state, S_HOLD);
    tick(1);
    check("rerise_brown2", state, S_BROWN);
    check("rerise_evt2", evt_cnt, 2);
    check("rerise_sys_rst", sys_rst, 1);

    // hold_len=0 gives a single HOLD cycle
    hold_len = 16'd0; bo_in = 1'b0;
    wait_state(S_HOLD, 20, ok);
    check("hold0_entry", state, S_HOLD);
    tick(1);
    check("hold0_run", state, S_RUN);
    check("hold0_sys_rst", sys_rst, 0);

    // Saturation: 2 events so far, 253 more reach 255, 5 more must not wrap
    filt_len = 4'd0;
    all_ok = 1'b1;
    for (int i = 0; i < 253; i++) begin
      bo_event(ok);
      all_ok = all_ok && ok;
    end
    check("sat_evt_255", evt_cnt, 255);
    for (int i = 0; i < 5; i++) begin
      bo_event(ok);
      all_ok = all_ok && ok;
    end
    check("sat_events_done", all_ok, 1);
    check("sat_no_wrap", evt_cnt, 255);

    clr = 1'b1; tick(1); clr = 1'b0;
    check("clr_evt_cnt", evt_cnt, 0);
    check("clr_bo_flag", bo_flag, 0);
    tick(1);
    check("clr_irq", irq, 0);

    // clr coincident with RUN->BROWN: set wins (filt_len=0 -> 4-edge latency)
    bo_in = 1'b1; tick(3); clr = 1'b1; tick(1); clr = 1'b0;
    check("clrset_state", state, S_BROWN);
    check("clrset_evt_cnt", evt_cnt, 1);
    check("clrset_bo_flag", bo_flag, 1);

    // Disable during BROWN, then re-enable with bo still high
    ena = 1'b0; tick(1);
    check("dis_state", state, S_OFF);
    check("dis_sys_rst", sys_rst, 0);
    check("dis_bo_flag", bo_flag, 1);
    check("dis_evt_cnt", evt_cnt, 1);
    tick(5);
    ena = 1'b1; tick(1);
    check("reen_run", state, S_RUN);
    tick(1);
    check("reen_brown", state, S_BROWN);
    check("reen_evt_cnt", evt_cnt, 2);
    check("reen_sys_rst", sys_rst, 1);

    // vunder and timed_out flags
    filt_len = 4'd3; bo_in = 1'b0;
    wait_state(S_RUN, 30, ok);
    check("vu_prep_run", state, S_RUN);
    clr = 1'b1; tick(1); clr = 1'b0; tick(2);
    check("vu_prep_flags", {bo_flag, vunder_flag, to_flag}, 0);
    vunder_in = 1'b1; tick(4); vunder_in = 1'b0; tick(10);
    check("vu_flag_set", vunder_flag, 1);
    check("vu_to_clear", to_flag, 0);
    timed_out_in = 1'b1; tick(6);
    check("to_flag_set", to_flag, 1);
    check("flags_irq", irq, 1);
    timed_out_in = 1'b0; tick(6);

    // Both ignored while OFF
    clr = 1'b1; tick(1); clr = 1'b0;
    ena = 1'b0; tick(2);
    check("off_state", state, S_OFF);
    vunder_in = 1'b1; timed_out_in = 1'b1; tick(12);
    check("off_vu_flag", vunder_flag, 0);
    check("off_to_flag", to_flag, 0);
    check("off_irq", irq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/brownout_supervisor.md
Name: brownout_supervisor

Overview:
Digital consumer of the brownout macro outputs (out, vunder, timed_out). Synchronises and deglitches them into the digital clock domain and drives a system reset with a programmable hold-off after supply recovery. Keeps sticky status flags, a saturating brownout event counter and a level interrupt for firmware. Sits between the brownout analog/digital pair and the chip reset/interrupt fabric.

Parameters:
SYNC_STAGES, 2, synchroniser depth for each asynchronous input (min 2)
FILT_W, 4, width of the deglitch length control
HOLD_W, 16, width of the reset hold-off counter
CNT_W, 8, width of the brownout event counter

Ports:
clk  input  1  digital clock
rst  input  1  synchronous, active-high reset
ena  input  1  supervisor enable
bo_in  input  1  brownout out from the macro, async; 1 = supply below otrip
vunder_in  input  1  vunder from the macro, async; 1 = undervoltage
timed_out_in  input  1  timed_out from the macro, async
filt_len  input  FILT_W  deglitch length; filter needs filt_len+1 stable cycles
hold_len  input  HOLD_W  extra reset cycles after brownout clears
clr  input  1  one-cycle pulse; clears flags and event counter
sys_rst  output  1  active-high system reset request
bo_flag  output  1  sticky: brownout event seen
vunder_flag  output  1  sticky: vunder rising edge seen
to_flag  output  1  sticky: timed_out rising edge seen
irq  output  1  level interrupt
evt_cnt  output  CNT_W  saturating brownout event count
state  output  2  FSM state: 0 OFF, 1 RUN, 2 BROWN, 3 HOLD

Behaviour:
- Reset (rst=1 at a clk edge): all sync/filter flops 0, state OFF, every output 0. Reset is synchronous only; no async clear path.
- Sync: bo_in, vunder_in and timed_out_in each pass through SYNC_STAGES flops.
- Filter, applied to bo and vunder:
  - Filtered value flips only after the synced value differs from it for filt_len+1 consecutive cycles.
  - Any mismatch break resets the run counter.
  - filt_len=0 gives a 1-cycle filter.
  - timed_out is synced only.
- Latency: bo_in rise (held) to sys_rst=1 is SYNC_STAGES+filt_len+2 clk edges. Defaults with filt_len=3 give 7.
- FSM, all transitions registered:
  - OFF: sys_rst=0. ena=1 -> RUN.
  - RUN: sys_rst=0. bo_filt=1 -> BROWN. On this transition: evt_cnt+1 (saturates at all-ones, no wrap) and bo_flag set.
  - BROWN: sys_rst=1. bo_filt=0 -> HOLD, loading the hold counter with hold_len.
  - HOLD: sys_rst=1; counter decrements each cycle. bo_filt=1 -> BROWN with no new event count. Counter==0 -> RUN, with sys_rst=0 in the same cycle as state RUN. hold_len=0 gives exactly 1 cycle in HOLD.
  - ena=0 in any state -> OFF next edge (highest priority). sys_rst drops, hold counter and filters clear. Flags and evt_cnt are retained.
- If bo_filt is already 1 when entering RUN from OFF: RUN lasts 1 cycle, then BROWN with an event counted.
- Flags:
  - vunder_flag sets on a vunder_filt 0->1 edge.
  - to_flag sets on a timed_out sync 0->1 edge.
  - Flags are set only when state != OFF.
  - clr clears all flags and evt_cnt. If a set and clr land in the same cycle, the set wins (flag=1, evt_cnt=1 if an event was counted).
- irq: registered OR of bo_flag, vunder_flag and to_flag. It lags the flags by 1 cycle.
- sys_rst is registered and glitch-free, and is derived from the next-state decode.

Decomposition:
- Package brownout_sup_pkg:
  - state enum (OFF, RUN, BROWN, HOLD) and its 2-bit encoding.
  - default parameter constants.
- One sub-module, brownout_deglitch: SYNC_STAGES synchroniser, FILT_W filter and rise-edge strobe output.
  - Instantiated twice: bo and vunder.
  - timed_out uses the same module with filt_len tied 0.

Test Plan:
- Reset/enable: rst=1 for 3 cycles, then ena=1 -> all outputs 0, state 0 then 1 the cycle after ena sampled.
- Glitch reject: filt_len=3, bo_in high for 3 cycles, then low -> sys_rst stays 0, evt_cnt=0. Held 4+ cycles -> sys_rst=1 exactly 7 edges after the rise, evt_cnt=1, bo_flag=1, irq=1 one cycle later.
- Hold-off:
  - hold_len=10, bo_in falls -> state HOLD, sys_rst low exactly 11 cycles after HOLD entry.
  - Repeat with bo_in re-rising at HOLD count 5 -> state BROWN, evt_cnt unchanged.
  - Repeat with hold_len=0 -> 1 HOLD cycle.
- Saturation/clr: CNT_W=8, 260 brownout events -> evt_cnt=255. clr pulse -> 0. clr coincident with a RUN->BROWN transition -> evt_cnt=1, bo_flag=1.
- Disable mid-operation: ena=0 during BROWN -> state OFF and sys_rst=0 next edge; flags retained. ena=1 with bo_in still high -> RUN for 1 cycle, then BROWN, evt_cnt+1.
- vunder/timed_out: a vunder_in pulse held filt_len+1 cycles sets vunder_flag; a timed_out_in 0->1 sets to_flag. Both are ignored while state is OFF.
